neg_mult_rr_arbiter: RTL
========================

# neg_mult_rr_arbiter

Round-robin arbiter and sequencer that shares one `dynamic_neg_mult` instance (P = ±B × A, fixed 4-cycle pipeline, no stall) among `NREQ` requesters. It accepts at most one operation per cycle over a valid/ready handshake and drives registered operands into the multiplier. A tag pipeline matched to the multiplier latency lets it return each product with the requester index that issued it. It sits between the requesting engines and the shared DSP multiplier.

## Interface
- `NREQ`, 4: number of requesters, 2..16
- `AW`, 27: A operand width, signed
- `BW`, 18: B operand width, signed
- `MW`, AW+BW: product width, signed
- `MLAT`, 4: multiplier latency, input capture edge to `pout` update
- `IDW`, $clog2(NREQ): requester index width
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `hold`  in  1  1 = grant nothing this cycle; in-flight operations still drain
- `req_valid`  in  NREQ  per-requester operation valid
- `req_ready`  out  NREQ  per-requester grant, one-hot or zero
- `req_a`  in  NREQ*AW  flattened A operands, requester i at bits [i*AW +: AW]
- `req_b`  in  NREQ*BW  flattened B operands
- `req_neg`  in  NREQ  1 = product −B×A, 0 = +B×A
- `m_subadd`  out  1  to multiplier `subadd`
- `m_ain`  out  AW  to multiplier `ain`
- `m_bin`  out  BW  to multiplier `bin`
- `m_pout`  in  MW  from multiplier `pout`
- `res_valid`  out  1  one-cycle result strobe; no backpressure
- `res_id`  out  IDW  requester index of the result
- `res_p`  out  MW  signed product
- `busy`  out  1  any operation in flight (issue register or tag pipeline)

## Operation
- Arbitration is combinational from `req_valid`, `hold` and pointer `last`:
  - Search order is last+1, last+2, … modulo NREQ.
  - The first requester found with `req_valid`=1 gets `req_ready`=1.
  - `req_ready` is all-zero if `hold`=1 or no requester is valid.
- `req_ready` does not depend on the requester seeing ready first. A requester may drop `req_valid` without a transfer.
- A transfer occurs when `req_valid[i]` and `req_ready[i]` are both 1. On that edge:
  - `last` takes the value i.
  - The issue register loads `m_ain`=req_a[i], `m_bin`=req_b[i], `m_subadd`=~req_neg[i].
  - The tag stage 0 loads {valid=1, id=i}.
- A cycle with no transfer loads the issue register with zeros (m_subadd=1) and tag valid=0. `last` is unchanged.
- The tag pipeline is stage 0 followed by MLAT shift stages. The last stage is aligned with `m_pout` for that operation.
- The output register loads `res_valid`, `res_id` and `res_p`=m_pout from the last tag stage.
- `res_p` is zero whenever `res_valid`=0.
- `busy` = OR of all tag valid bits.
- The operand signs need no handling here. The full-range product fits in MW. The multiplier handles −(−2^(BW−1)).
- Reset (any cycle, including mid-operation):
  - Clears the issue register and all tag valids.
  - Sets `last`=NREQ−1, so requester 0 has first priority.
  - Products already inside the multiplier are discarded and never produce `res_valid`.
- Reset values: `req_ready`=0 while rst=1; m_ain=0, m_bin=0, m_subadd=1; res_valid=0, res_id=0, res_p=0; busy=0.

## Timing
- Handshake in cycle E. Operands appear on `m_*` in E+1. The multiplier captures them at the end of E+1.
- `m_pout` is valid in cycle E+1+MLAT.
- `res_valid`/`res_p`/`res_id` are valid in cycle E+MLAT+2, which is E+6 at default.
- Throughput is one operation per cycle. Back-to-back grants give back-to-back `res_valid` in grant order.
- `hold` is sampled in the same cycle as the grant. Asserting `hold` in cycle E blocks the grant in E only.
- `busy` falls in the cycle after the last tag leaves the pipeline, i.e. together with that result's `res_valid`.

## Test plan
- Single op: after reset, requester 2 presents a=3, b=5, neg=0 for one cycle E -> req_ready=4'b0100 in E; res_valid in E+6 with res_id=2, res_p=15; no other strobes.
- Negate: requester 0 presents a=−7, b=9, neg=1 -> res_p=+63, res_id=0.
- Fairness: all 4 valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; res_valid high 8 consecutive cycles with ids in the same order and correct products.
- Extremes: a=−2^26, b=−2^17, neg=0 -> res_p=+2^43; same operands with neg=1 -> res_p=−2^43; a=2^26−1, b=2^17−1 -> (2^26−1)(2^17−1).
- Hold/pointer: requesters 1 and 3 valid, hold=1 for 3 cycles -> no ready; then hold=0 with last=1 -> requester 3 granted first, then 1.
- Reset mid-op: issue 3 ops, assert rst for 1 cycle two cycles later -> no res_valid for those ops; busy=0 after reset; a new op to requester 0 goes first and returns normally.

Source files
------------

// File: rtl/neg_mult_rr_arbiter_if.sv
// Bundle between the round-robin arbiter, its requesters, the shared
// multiplier and the result consumer. The arbiter uses the slave view; the
// master view is the surrounding environment (requesters, multiplier, sink).
interface neg_mult_rr_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 27,
    parameter int unsigned BW   = 18,
    parameter int unsigned MW   = AW + BW,
    parameter int unsigned IDW  = $clog2(NREQ)
);
    // Requester side
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_a;
    logic [NREQ*BW-1:0] req_b;
    logic [NREQ-1:0]    req_neg;

    // Shared multiplier side
    logic               m_subadd;
    logic [AW-1:0]      m_ain;
    logic [BW-1:0]      m_bin;
    logic [MW-1:0]      m_pout;

    // Result side
    logic               res_valid;
    logic [IDW-1:0]     res_id;
    logic [MW-1:0]      res_p;

    modport master (
        output req_valid, req_a, req_b, req_neg, m_pout,
        input  req_ready, m_subadd, m_ain, m_bin, res_valid, res_id, res_p
    );

    modport slave (
        input  req_valid, req_a, req_b, req_neg, m_pout,
        output req_ready, m_subadd, m_ain, m_bin, res_valid, res_id, res_p
    );
endinterface

// File: rtl/neg_mult_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one fixed-latency +/-B*A multiplier
// among NREQ requesters. One grant per cycle; a tag pipeline matched to the
// multiplier latency returns each product with the issuing requester index.
module neg_mult_rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 27,
    parameter int unsigned BW   = 18,
    parameter int unsigned MW   = AW + BW,
    parameter int unsigned MLAT = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_hold,
    output logic                     o_busy,
    neg_mult_rr_arbiter_if.slave     io_bus
);

    // Per-requester operand views of the flattened buses
    logic [AW-1:0]  w_a [NREQ];
    logic [BW-1:0]  w_b [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_a[gi] = io_bus.req_a[gi*AW +: AW];
        assign w_b[gi] = io_bus.req_b[gi*BW +: BW];
    end

    // Arbitration pointer: index of the most recently granted requester
    logic [IDW-1:0] r_last;

    // Grant decode results
    logic [NREQ-1:0] w_ready;
    logic            w_found;
    logic [IDW-1:0]  w_gnt_id;
    logic [IDW-1:0]  w_idx;

    // Issue register driving the multiplier
    logic [AW-1:0]   r_ain;
    logic [BW-1:0]   r_bin;
    logic            r_subadd;

    // Tag pipeline: stage 0 runs alongside the issue register, stage MLAT
    // lines up with m_pout for the same operation
    logic [MLAT:0]   r_tag_v;
    logic [IDW-1:0]  r_tag_id [MLAT+1];

    // Output register
    logic            r_res_valid;
    logic [IDW-1:0]  r_res_id;
    logic [MW-1:0]   r_res_p;

    // Search last+1, last+2, ... modulo NREQ; first valid requester wins
    always_comb begin
        w_ready  = '0;
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        if (!i_rst && !i_hold) begin
            for (int unsigned k = 1; k <= NREQ; k++) begin
                w_idx = IDW'((32'(r_last) + k) % NREQ);
                if (!w_found && io_bus.req_valid[w_idx]) begin
                    w_found         = 1'b1;
                    w_gnt_id        = w_idx;
                    w_ready[w_idx]  = 1'b1;
                end
            end
        end
    end

    // Pointer update and operand issue; idle cycles issue zeros
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last   <= IDW'(NREQ - 1);
            r_ain    <= '0;
            r_bin    <= '0;
            r_subadd <= 1'b1;
        end else if (w_found) begin
            r_last   <= w_gnt_id;
            r_ain    <= w_a[w_gnt_id];
            r_bin    <= w_b[w_gnt_id];
            r_subadd <= ~io_bus.req_neg[w_gnt_id];
        end else begin
            r_ain    <= '0;
            r_bin    <= '0;
            r_subadd <= 1'b1;
        end
    end

    // Tag shift pipeline; reset drops tags so in-flight products are discarded
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tag_v <= '0;
            for (int i = 0; i <= MLAT; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_v     <= {r_tag_v[MLAT-1:0], w_found};
            r_tag_id[0] <= w_found ? w_gnt_id : '0;
            for (int i = 1; i <= MLAT; i++) begin
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    // Result register; id and product forced to zero when no result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_p     <= '0;
        end else begin
            r_res_valid <= r_tag_v[MLAT];
            r_res_id    <= r_tag_v[MLAT] ? r_tag_id[MLAT] : '0;
            r_res_p     <= r_tag_v[MLAT] ? io_bus.m_pout : '0;
        end
    end

    assign io_bus.req_ready = w_ready;
    assign io_bus.m_ain     = r_ain;
    assign io_bus.m_bin     = r_bin;
    assign io_bus.m_subadd  = r_subadd;
    assign io_bus.res_valid = r_res_valid;
    assign io_bus.res_id    = r_res_id;
    assign io_bus.res_p     = r_res_p;
    assign o_busy           = |r_tag_v;

endmodule
